// File: rtl/audio_sample_bridge_pkg.sv
// Shared constants and types for the audio sample bridge.
// Build option: AUDIO_BRIDGE_DROP_OLDEST_EN (see top level).
package audio_bridge_pkg;

    localparam int AUDIO_DW         = 32;
    localparam int AUDIO_FIFO_DEPTH = 8;
    localparam int AUDIO_CNT_W      = 16;

    typedef logic [AUDIO_DW-1:0] sample_t;

endpackage

// File: rtl/audio_sample_bridge_if.sv
// Codec stream, core access and status bundle for one audio channel.
// slave = bridge side, master = codec/core side.
interface audio_sample_bridge_if
    import audio_bridge_pkg::*;
#(
    parameter int DW    = AUDIO_DW,
    parameter int DEPTH = AUDIO_FIFO_DEPTH,
    parameter int CW    = AUDIO_CNT_W
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [DW-1:0] adc_data;
    logic          adc_valid;
    logic          adc_ready;
    logic          cpu_rd;
    logic [DW-1:0] cpu_rd_data;
    logic          cpu_rd_avail;
    logic [LW-1:0] adc_level;
    logic          cpu_wr;
    logic [DW-1:0] cpu_wr_data;
    logic          cpu_wr_full;
    logic [DW-1:0] dac_data;
    logic          dac_valid;
    logic          dac_ready;
    logic [CW-1:0] overrun_cnt;
    logic [CW-1:0] underrun_cnt;
    logic [CW-1:0] drop_cnt;

    modport slave (
        input  adc_data, adc_valid, cpu_rd,
        input  cpu_wr, cpu_wr_data, dac_ready,
        output adc_ready, cpu_rd_data, cpu_rd_avail,
        output adc_level, cpu_wr_full,
        output dac_data, dac_valid,
        output overrun_cnt, underrun_cnt, drop_cnt
    );

    modport master (
        output adc_data, adc_valid, cpu_rd,
        output cpu_wr, cpu_wr_data, dac_ready,
        input  adc_ready, cpu_rd_data, cpu_rd_avail,
        input  adc_level, cpu_wr_full,
        input  dac_data, dac_valid,
        input  overrun_cnt, underrun_cnt, drop_cnt
    );

endinterface

// File: rtl/audio_sample_bridge_fifo.sv
// First-word fall-through FIFO with occupancy counter.
// Caller may push while full only when popping in the same cycle.
module sample_fifo
    import audio_bridge_pkg::*;
#(
    parameter int DW    = AUDIO_DW,
    parameter int DEPTH = AUDIO_FIFO_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [DW-1:0]              i_din,
    output logic [DW-1:0]              o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_count;

    always_ff @(posedge clock) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == FULL_LVL);
    assign o_empty = (r_count == '0);
    assign o_level = r_count;

endmodule

// File: rtl/audio_sample_bridge.sv
// Per-channel codec <-> core sample bridge with error counters.
// Define AUDIO_BRIDGE_DROP_OLDEST_EN to overwrite the oldest ADC sample instead of stalling.
module audio_sample_bridge
    import audio_bridge_pkg::*;
#(
    parameter int DW    = AUDIO_DW,
    parameter int DEPTH = AUDIO_FIFO_DEPTH,
    parameter int CW    = AUDIO_CNT_W
) (
    input  logic                  clock,
    input  logic                  reset,
    audio_sample_bridge_if.slave  bus
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic          w_adc_push;
    logic          w_adc_pop;
    logic          w_adc_full;
    logic          w_adc_empty;
    logic [LW-1:0] w_adc_level;
    logic [DW-1:0] w_adc_head;
    logic          w_adc_ready;

    logic          w_dac_push;
    logic          w_dac_pop;
    logic          w_dac_full;
    logic          w_dac_empty;
    logic [LW-1:0] w_dac_level;
    logic [DW-1:0] w_dac_head;

    logic          w_ovr_inc;
    logic          w_und_inc;
    logic          w_drp_inc;

    logic [CW-1:0] r_overrun_cnt;
    logic [CW-1:0] r_underrun_cnt;
    logic [CW-1:0] r_drop_cnt;

    assign w_und_inc = bus.cpu_rd && w_adc_empty;

`ifdef AUDIO_BRIDGE_DROP_OLDEST_EN
    logic w_overwrite;
    // A core read in the same cycle frees the slot, so that case is no overrun.
    assign w_overwrite = bus.adc_valid && w_adc_full && !bus.cpu_rd;
    assign w_adc_ready = 1'b1;
    assign w_adc_push  = bus.adc_valid;
    assign w_adc_pop   = (bus.cpu_rd && !w_adc_empty) || w_overwrite;
    assign w_ovr_inc   = w_overwrite;
`else
    assign w_adc_ready = !w_adc_full;
    assign w_adc_push  = bus.adc_valid && w_adc_ready;
    assign w_adc_pop   = bus.cpu_rd && !w_adc_empty;
    assign w_ovr_inc   = bus.adc_valid && !w_adc_ready;
`endif

    assign w_dac_push = bus.cpu_wr && !w_dac_full;
    assign w_drp_inc  = bus.cpu_wr && w_dac_full;
    assign w_dac_pop  = !w_dac_empty && bus.dac_ready;

    sample_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_adc_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_adc_push),
        .i_pop   (w_adc_pop),
        .i_din   (bus.adc_data),
        .o_dout  (w_adc_head),
        .o_full  (w_adc_full),
        .o_empty (w_adc_empty),
        .o_level (w_adc_level)
    );

    sample_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_dac_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_dac_push),
        .i_pop   (w_dac_pop),
        .i_din   (bus.cpu_wr_data),
        .o_dout  (w_dac_head),
        .o_full  (w_dac_full),
        .o_empty (w_dac_empty),
        .o_level (w_dac_level)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overrun_cnt  <= '0;
            r_underrun_cnt <= '0;
            r_drop_cnt     <= '0;
        end else begin
            if (w_ovr_inc && r_overrun_cnt != CNT_MAX)
                r_overrun_cnt <= r_overrun_cnt + 1'b1;
            if (w_und_inc && r_underrun_cnt != CNT_MAX)
                r_underrun_cnt <= r_underrun_cnt + 1'b1;
            if (w_drp_inc && r_drop_cnt != CNT_MAX)
                r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign bus.adc_ready    = w_adc_ready;
    assign bus.cpu_rd_data  = w_adc_head;
    assign bus.cpu_rd_avail = !w_adc_empty;
    assign bus.adc_level    = w_adc_level;
    assign bus.cpu_wr_full  = w_dac_full;
    assign bus.dac_data     = w_dac_head;
    assign bus.dac_valid    = !w_dac_empty;
    assign bus.overrun_cnt  = r_overrun_cnt;
    assign bus.underrun_cnt = r_underrun_cnt;
    assign bus.drop_cnt     = r_drop_cnt;

    // DAC occupancy is not exported; full/empty are enough for the core.
    logic w_unused;
    assign w_unused = ^w_dac_level;

endmodule

// File: tb/tb_audio_sample_bridge.sv
// Directed self-checking bench for audio_sample_bridge (DEPTH=8).
// Expectations follow AUDIO_BRIDGE_DROP_OLDEST_EN when defined.
module tb_audio_sample_bridge;
    import audio_bridge_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    audio_sample_bridge_if #(.DW(32), .DEPTH(8), .CW(16)) bus ();

    audio_sample_bridge #(
        .DW    (32),
        .DEPTH (8),
        .CW    (16)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.adc_data    = '0;
        bus.adc_valid   = 1'b0;
        bus.cpu_rd      = 1'b0;
        bus.cpu_wr      = 1'b0;
        bus.cpu_wr_data = '0;
        bus.dac_ready   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        n_cmp++;
        if (bus.adc_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_adc_ready got %0b want 1", bus.adc_ready);
        end
        n_cmp++;
        if (bus.cpu_rd_avail !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_avail got %0b want 0", bus.cpu_rd_avail);
        end
        n_cmp++;
        if (bus.adc_level !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_level got %0d want 0", bus.adc_level);
        end
        n_cmp++;
        if (bus.cpu_wr_full !== 1'b0 || bus.dac_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_dac got full=%0b valid=%0b want 0/0",
                     bus.cpu_wr_full, bus.dac_valid);
        end
        n_cmp++;
        if (bus.overrun_cnt !== 16'd0 || bus.underrun_cnt !== 16'd0 ||
            bus.drop_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_cnt got %0d/%0d/%0d want 0/0/0",
                     bus.overrun_cnt, bus.underrun_cnt, bus.drop_cnt);
        end
    endtask

    task automatic test_adc_basic();
        sample_t exp_q[3];
        exp_q[0] = 32'h11;
        exp_q[1] = 32'h22;
        exp_q[2] = 32'h33;
        for (int i = 0; i < 3; i++) begin
            bus.adc_valid = 1'b1;
            bus.adc_data  = exp_q[i];
            tick();
        end
        bus.adc_valid = 1'b0;
        n_cmp++;
        if (bus.adc_level !== 4'd3) begin
            n_bad++;
            $display("FAIL adc3_level got %0d want 3", bus.adc_level);
        end
        for (int i = 0; i < 3; i++) begin
            bus.cpu_rd = 1'b1;
            n_cmp++;
            if (bus.cpu_rd_avail !== 1'b1 || bus.cpu_rd_data !== exp_q[i]) begin
                n_bad++;
                $display("FAIL adc3_rd%0d got %0b/%h want 1/%h",
                         i, bus.cpu_rd_avail, bus.cpu_rd_data, exp_q[i]);
            end
            tick();
        end
        bus.cpu_rd = 1'b0;
        n_cmp++;
        if (bus.cpu_rd_avail !== 1'b0 || bus.adc_level !== 4'd0) begin
            n_bad++;
            $display("FAIL adc3_empty got avail=%0b lvl=%0d want 0/0",
                     bus.cpu_rd_avail, bus.adc_level);
        end
        n_cmp++;
        if (bus.underrun_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL adc3_underrun got %0d want 0", bus.underrun_cnt);
        end
    endtask

    task automatic test_overrun();
        logic    exp_rdy;
        sample_t exp_head;
        do_reset();
`ifdef AUDIO_BRIDGE_DROP_OLDEST_EN
        exp_rdy  = 1'b1;
        exp_head = 32'd3;
`else
        exp_rdy  = 1'b0;
        exp_head = 32'd1;
`endif
        for (int i = 0; i < 10; i++) begin
            bus.adc_valid = 1'b1;
            bus.adc_data  = 32'(i + 1);
            tick();
        end
        bus.adc_valid = 1'b0;
        n_cmp++;
        if (bus.adc_ready !== exp_rdy) begin
            n_bad++;
            $display("FAIL ovr_ready got %0b want %0b", bus.adc_ready, exp_rdy);
        end
        n_cmp++;
        if (bus.adc_level !== 4'd8) begin
            n_bad++;
            $display("FAIL ovr_level got %0d want 8", bus.adc_level);
        end
        n_cmp++;
        if (bus.overrun_cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL ovr_cnt got %0d want 2", bus.overrun_cnt);
        end
        n_cmp++;
        if (bus.cpu_rd_data !== exp_head) begin
            n_bad++;
            $display("FAIL ovr_head got %h want %h", bus.cpu_rd_data, exp_head);
        end
    endtask

    // Continues from a full ADC FIFO left by test_overrun.
    task automatic test_full_rd_and_valid();
        logic [3:0]  exp_lvl;
        logic [15:0] exp_ovr;
        sample_t     exp_q[8];
        int          n_left;
`ifdef AUDIO_BRIDGE_DROP_OLDEST_EN
        exp_lvl = 4'd8;
        exp_ovr = 16'd2;
        n_left  = 8;
        for (int i = 0; i < 7; i++) exp_q[i] = 32'(i + 4);
        exp_q[7] = 32'hEE;
`else
        exp_lvl = 4'd7;
        exp_ovr = 16'd3;
        n_left  = 7;
        for (int i = 0; i < 7; i++) exp_q[i] = 32'(i + 2);
        exp_q[7] = 32'h0;
`endif
        bus.adc_valid = 1'b1;
        bus.adc_data  = 32'hEE;
        bus.cpu_rd    = 1'b1;
        tick();
        bus.adc_valid = 1'b0;
        bus.cpu_rd    = 1'b0;
        n_cmp++;
        if (bus.adc_level !== exp_lvl) begin
            n_bad++;
            $display("FAIL fullrd_level got %0d want %0d", bus.adc_level, exp_lvl);
        end
        n_cmp++;
        if (bus.adc_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL fullrd_ready got %0b want 1", bus.adc_ready);
        end
        n_cmp++;
        if (bus.overrun_cnt !== exp_ovr) begin
            n_bad++;
            $display("FAIL fullrd_ovr got %0d want %0d", bus.overrun_cnt, exp_ovr);
        end
        for (int i = 0; i < n_left; i++) begin
            bus.cpu_rd = 1'b1;
            n_cmp++;
            if (bus.cpu_rd_avail !== 1'b1 || bus.cpu_rd_data !== exp_q[i]) begin
                n_bad++;
                $display("FAIL fullrd_drain%0d got %0b/%h want 1/%h",
                         i, bus.cpu_rd_avail, bus.cpu_rd_data, exp_q[i]);
            end
            tick();
        end
        bus.cpu_rd = 1'b0;
        n_cmp++;
        if (bus.cpu_rd_avail !== 1'b0) begin
            n_bad++;
            $display("FAIL fullrd_empty got %0b want 0", bus.cpu_rd_avail);
        end
    endtask

    task automatic test_underrun();
        do_reset();
        bus.cpu_rd = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (bus.underrun_cnt !== 16'd5 || bus.adc_level !== 4'd0) begin
            n_bad++;
            $display("FAIL und5 got cnt=%0d lvl=%0d want 5/0",
                     bus.underrun_cnt, bus.adc_level);
        end
        bus.adc_valid = 1'b1;
        bus.adc_data  = 32'hAB;
        tick();
        bus.adc_valid = 1'b0;
        bus.cpu_rd    = 1'b0;
        n_cmp++;
        if (bus.cpu_rd_avail !== 1'b1 || bus.cpu_rd_data !== 32'hAB ||
            bus.adc_level !== 4'd1) begin
            n_bad++;
            $display("FAIL und_push got %0b/%h/%0d want 1/000000ab/1",
                     bus.cpu_rd_avail, bus.cpu_rd_data, bus.adc_level);
        end
        n_cmp++;
        if (bus.underrun_cnt !== 16'd6) begin
            n_bad++;
            $display("FAIL und_cnt got %0d want 6", bus.underrun_cnt);
        end
    endtask

    task automatic test_dac();
        bus.dac_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.cpu_wr      = 1'b1;
            bus.cpu_wr_data = 32'h100 + 32'(i);
            tick();
            if (i == 7) begin
                n_cmp++;
                if (bus.cpu_wr_full !== 1'b1) begin
                    n_bad++;
                    $display("FAIL dac_full8 got %0b want 1", bus.cpu_wr_full);
                end
            end
        end
        bus.cpu_wr = 1'b0;
        n_cmp++;
        if (bus.drop_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL dac_drop got %0d want 1", bus.drop_cnt);
        end
        bus.dac_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (bus.dac_valid !== 1'b1 || bus.dac_data !== 32'h100 + 32'(i)) begin
                n_bad++;
                $display("FAIL dac_drain%0d got %0b/%h want 1/%h",
                         i, bus.dac_valid, bus.dac_data, 32'h100 + 32'(i));
            end
            tick();
        end
        n_cmp++;
        if (bus.dac_valid !== 1'b0 || bus.cpu_wr_full !== 1'b0) begin
            n_bad++;
            $display("FAIL dac_empty got valid=%0b full=%0b want 0/0",
                     bus.dac_valid, bus.cpu_wr_full);
        end
        bus.dac_ready = 1'b0;
    endtask

    // Counters are non-zero from earlier tests; reset must clear them.
    task automatic test_mid_reset();
        for (int i = 0; i < 4; i++) begin
            bus.adc_valid = 1'b1;
            bus.adc_data  = 32'h50 + 32'(i);
            tick();
        end
        bus.adc_valid   = 1'b0;
        bus.cpu_wr      = 1'b1;
        bus.cpu_wr_data = 32'h77;
        tick();
        bus.cpu_wr = 1'b0;
        n_cmp++;
        if (bus.adc_level !== 4'd5 || bus.dac_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_pre got lvl=%0d dv=%0b want 5/1",
                     bus.adc_level, bus.dac_valid);
        end
        bus.adc_valid = 1'b1;
        bus.adc_data  = 32'h99;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.adc_valid = 1'b0;
        n_cmp++;
        if (bus.adc_level !== 4'd0 || bus.cpu_rd_avail !== 1'b0 ||
            bus.dac_valid !== 1'b0 || bus.adc_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_fifo got lvl=%0d av=%0b dv=%0b rdy=%0b want 0/0/0/1",
                     bus.adc_level, bus.cpu_rd_avail, bus.dac_valid, bus.adc_ready);
        end
        n_cmp++;
        if (bus.overrun_cnt !== 16'd0 || bus.underrun_cnt !== 16'd0 ||
            bus.drop_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL mid_cnt got %0d/%0d/%0d want 0/0/0",
                     bus.overrun_cnt, bus.underrun_cnt, bus.drop_cnt);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_adc_basic();
        test_overrun();
        test_full_rd_and_valid();
        test_underrun();
        test_dac();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/audio_sample_bridge.md
Name: audio_sample_bridge

Overview:
- Buffers audio samples between the codec streaming interface and one RISC-V core. One instance per channel; left and right are instantiated separately.
- ADC path: the codec's valid/ready stream feeds a FIFO, which the core drains with a read strobe.
- DAC path: the core pushes samples with a write strobe into a FIFO, which drains to the codec's valid/ready stream.
- Also maintains saturating error counters for overrun, underrun and drop.

Parameters:
- DW, 32, sample width in bits (matches codec stream data width).
- DEPTH, 8, entries per FIFO. Must be a power of two and at least 2.
- CW, 16, width of each error counter.

Ports:
- clock  in  1  system clock (50 MHz domain)
- reset  in  1  synchronous, active-high reset
- adc_data  in  DW  sample from codec ADC stream
- adc_valid  in  1  ADC stream valid
- adc_ready  out  1  ADC stream ready
- cpu_rd  in  1  core read strobe; pops one sample per cycle when asserted
- cpu_rd_data  out  DW  head of ADC FIFO (first-word fall-through)
- cpu_rd_avail  out  1  ADC FIFO non-empty
- adc_level  out  $clog2(DEPTH)+1  ADC FIFO occupancy
- cpu_wr  in  1  core write strobe
- cpu_wr_data  in  DW  sample from core
- cpu_wr_full  out  1  DAC FIFO full
- dac_data  out  DW  head of DAC FIFO to codec
- dac_valid  out  1  DAC stream valid
- dac_ready  in  1  DAC stream ready
- overrun_cnt  out  CW  ADC overrun events
- underrun_cnt  out  CW  reads attempted while ADC FIFO empty
- drop_cnt  out  CW  writes attempted while DAC FIFO full

Behaviour:
- Clocking and reset
  - All state updates on the rising edge of clock.
  - reset is synchronous, active-high, and has priority over every other input.
  - On reset, both FIFOs empty (pointers and occupancy = 0) and all counters = 0.
  - Output values while reset is asserted or just released: adc_ready=1, cpu_rd_avail=0, adc_level=0, cpu_wr_full=0, dac_valid=0. cpu_rd_data and dac_data are don't-care while their FIFO is empty.
  - Reset mid-operation discards all buffered samples. Storage contents need not be cleared.
- ADC push
  - adc_ready = !adc_full.
  - A push occurs when adc_valid && adc_ready.
  - Each cycle with adc_valid && !adc_ready increments overrun_cnt.
- CPU pop
  - A pop occurs when cpu_rd && cpu_rd_avail.
  - cpu_rd && !cpu_rd_avail does not change the FIFO and increments underrun_cnt.
- ADC latency
  - A sample pushed at edge N appears on cpu_rd_data with cpu_rd_avail=1 in the cycle after edge N.
  - The pop takes effect at the edge where cpu_rd is sampled.
- ADC FIFO boundary conditions
  - Push and pop in the same cycle when non-empty and not full: occupancy unchanged.
  - Full with adc_valid and cpu_rd: pop only. adc_ready rises the following cycle.
  - Empty with adc_valid and cpu_rd: push only, and underrun_cnt increments.
- DAC path
  - A push occurs when cpu_wr && !cpu_wr_full.
  - cpu_wr while full discards cpu_wr_data and increments drop_cnt.
  - dac_valid = !dac_empty. dac_data = head.
  - A pop occurs when dac_valid && dac_ready.
  - Same-cycle push/pop rules and one-cycle fall-through latency as the ADC FIFO.
  - cpu_wr_full = dac_full.
- Pointers and occupancy
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Full/empty are derived from an occupancy counter of $clog2(DEPTH)+1 bits.
- Counters
  - Saturate at 2^CW-1 and never wrap.
  - Each increments by at most 1 per cycle.

Optional Feature:
- Macro: AUDIO_BRIDGE_DROP_OLDEST_EN.
- When defined, the ADC path never stalls the codec:
  - adc_ready is tied to 1.
  - A push into a full ADC FIFO overwrites the oldest entry (pop and push in the same cycle).
  - Occupancy stays at DEPTH, and overrun_cnt increments once per overwrite.
  - If cpu_rd also asserts in that cycle, it is a normal pop plus push. This is not an overrun.
- When not defined, behaviour is exactly as specified above (backpressure plus per-cycle overrun count).

Decomposition:
- Package audio_bridge_pkg holds:
  - default constants AUDIO_DW=32, AUDIO_FIFO_DEPTH=8, AUDIO_CNT_W=16;
  - sample_t typedef (logic [AUDIO_DW-1:0]).
- Sub-module sample_fifo:
  - parameterised DW and DEPTH;
  - interface: push/pop/din/dout/full/empty/level;
  - instantiated twice, once for ADC and once for DAC.
- The top level implements handshake decode, the drop-oldest option and the saturating counters.

Test Plan:
- Reset, then push 3 ADC samples 0x11, 0x22, 0x33 with cpu_rd=0 -> adc_level=3 and cpu_rd_data=0x11. Then 3 cpu_rd pulses -> reads 0x11, 0x22, 0x33, then cpu_rd_avail=0.
- DEPTH=8: push 10 samples with adc_valid held and no reads -> adc_ready=0 after 8 pushes and overrun_cnt=2 (feature off). With AUDIO_BRIDGE_DROP_OLDEST_EN: adc_ready=1, head=sample 3, overrun_cnt=2.
- cpu_rd on empty FIFO for 5 cycles -> underrun_cnt=5, adc_level stays 0. Simultaneous adc_valid with value 0xAB -> push succeeds and cpu_rd_data=0xAB the next cycle.
- cpu_wr 9 samples with dac_ready=0 -> cpu_wr_full=1 after 8 and drop_cnt=1. Then dac_ready=1 -> exactly 8 samples drained in order, then dac_valid=0.
- Full ADC FIFO with adc_valid=1 and cpu_rd=1 in the same cycle -> level goes 8->7, no push that cycle, adc_ready=1 the next cycle (feature off).
- Reset asserted mid-stream with level=5 -> the next cycle has level=0, cpu_rd_avail=0, dac_valid=0 and all counters 0.
